// File: rtl/xvec2_vscale_vec_mul_div_pkg.sv
// xvec2_vscale_vec_mul_div_pkg: shared widths, op codes and FSM encodings for the vector mul/div unit
package xvec2_vscale_vec_mul_div_pkg;
   localparam int XPR_LEN          = 32;
   localparam int VEC_XPR_LEN      = 2 * XPR_LEN;
   localparam int MD_OP_WIDTH      = 2;
   localparam int MD_OUT_SEL_WIDTH = 2;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;
   localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO = 2'd0;
   localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI = 2'd1;
   localparam logic [1:0] MD_STATE_IDLE         = 2'd0;
   localparam logic [1:0] MD_STATE_COMPUTE      = 2'd1;
   localparam logic [1:0] MD_STATE_SETUP_OUTPUT = 2'd2;
   localparam logic [1:0] MD_STATE_DONE         = 2'd3;
endpackage

// File: rtl/xvec2_vscale_vec_mul_div_md_lane.sv
// xvec2_vscale_md_lane: one lane of operand magnitudes, iteration step and sign fix-up
module xvec2_vscale_md_lane
   import xvec2_vscale_vec_mul_div_pkg::*;
#(
   parameter int W = XPR_LEN
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        load,
   input  logic                        step,
   input  logic                        finish,
   input  logic [MD_OP_WIDTH-1:0]      op,
   input  logic [MD_OUT_SEL_WIDTH-1:0] out_sel,
   input  logic                        in_1_signed,
   input  logic                        in_2_signed,
   input  logic [W-1:0]                in_1,
   input  logic [W-1:0]                in_2,
   output logic [W-1:0]                result
);
   logic [2*W-1:0] acc;
   logic [W-1:0]   d;
   logic [W-1:0]   q;
   logic           neg_a;
   logic           neg_x;
   logic           a_neg;
   logic           b_neg;
   logic [W:0]     t;
   logic [W:0]     diff;
   logic [2*W-1:0] prod;
   logic [W-1:0]   res_next;
   // operand signs, restoring-divide trial subtraction and signed result selection
   always_comb begin
      a_neg = in_1_signed & in_1[W-1];
      b_neg = in_2_signed & in_2[W-1];
      t = {acc[W-1:0], q[W-1]};
      diff = t - {1'b0, d};
      prod = neg_x ? -acc : acc;
      res_next = (op == MD_OP_MUL) ? ((out_sel == MD_OUT_HI) ? prod[2*W-1:W] : prod[W-1:0]) :
                 (op == MD_OP_REM) ? (neg_a ? -acc[W-1:0] : acc[W-1:0]) :
                 ((neg_x & |d) ? -q : q);
   end
   // q holds the multiplier/dividend shifting out MSB first; acc holds product or partial remainder
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         d <= '0;
         q <= '0;
         neg_a <= 1'b0;
         neg_x <= 1'b0;
         result <= '0;
      end else if (load) begin
         acc <= '0;
         d <= b_neg ? -in_2 : in_2;
         q <= a_neg ? -in_1 : in_1;
         neg_a <= a_neg;
         neg_x <= a_neg ^ b_neg;
      end else if (step) begin
         acc <= (op == MD_OP_MUL) ? {acc[2*W-2:0], 1'b0} + (q[W-1] ? {{W{1'b0}}, d} : '0) :
                {{W{1'b0}}, diff[W] ? t[W-1:0] : diff[W-1:0]};
         q <= {q[W-2:0], (op != MD_OP_MUL) & ~diff[W]};
      end else if (finish) begin
         result <= res_next;
      end
   end
endmodule

// File: rtl/xvec2_vscale_vec_mul_div.sv
// xvec2_vscale_vec_mul_div: iterative packed-lane multiply/divide/remainder unit with shared FSM
module xvec2_vscale_vec_mul_div
   import xvec2_vscale_vec_mul_div_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int LANE_W = XPR_LEN
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_kill,
   input  logic [MD_OP_WIDTH-1:0]      req_op,
   input  logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel,
   input  logic                        req_in_1_signed,
   input  logic                        req_in_2_signed,
   input  logic [LANES*LANE_W-1:0]     req_in_1,
   input  logic [LANES*LANE_W-1:0]     req_in_2,
   output logic                        resp_valid,
   output logic [LANES*LANE_W-1:0]     resp_result
);
   localparam int CW = $clog2(LANE_W);
   logic [1:0]                  state;
   logic [CW-1:0]               counter;
   logic [MD_OP_WIDTH-1:0]      op_r;
   logic [MD_OUT_SEL_WIDTH-1:0] out_sel_r;
   logic                        load;
   logic                        step;
   logic                        finish;
   assign req_ready = state == MD_STATE_IDLE;
   assign resp_valid = state == MD_STATE_DONE;
   assign load = req_ready & req_valid & ~req_kill;
   assign step = (state == MD_STATE_COMPUTE) & ~req_kill;
   assign finish = (state == MD_STATE_SETUP_OUTPUT) & ~req_kill;
   // shared sequencer: accept, LANE_W compute steps, result setup, one-cycle response
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_STATE_IDLE;
         counter <= '0;
         op_r <= MD_OP_MUL;
         out_sel_r <= MD_OUT_LO;
      end else if (req_kill && state != MD_STATE_IDLE) begin
         state <= MD_STATE_IDLE;
      end else begin
         case (state)
            MD_STATE_IDLE: if (load) begin
               state <= MD_STATE_COMPUTE;
               counter <= CW'(LANE_W - 1);
               op_r <= req_op;
               out_sel_r <= req_out_sel;
            end
            MD_STATE_COMPUTE: begin
               counter <= counter - CW'(1);
               if (counter == '0) state <= MD_STATE_SETUP_OUTPUT;
            end
            MD_STATE_SETUP_OUTPUT: state <= MD_STATE_DONE;
            default: state <= MD_STATE_IDLE;
         endcase
      end
   end
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      xvec2_vscale_md_lane #(.W(LANE_W)) u_lane (
         .clk        (clk),
         .reset      (reset),
         .load       (load),
         .step       (step),
         .finish     (finish),
         .op         (op_r),
         .out_sel    (out_sel_r),
         .in_1_signed(req_in_1_signed),
         .in_2_signed(req_in_2_signed),
         .in_1       (req_in_1[i*LANE_W +: LANE_W]),
         .in_2       (req_in_2[i*LANE_W +: LANE_W]),
         .result     (resp_result[i*LANE_W +: LANE_W])
      );
   end
endmodule

// File: tb/tb_xvec2_vscale_vec_mul_div.sv
// tb_xvec2_vscale_vec_mul_div: scoreboard bench for the packed-lane mul/div unit
module tb_xvec2_vscale_vec_mul_div;
   import xvec2_vscale_vec_mul_div_pkg::*;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_kill = 1'b0;
   logic [1:0]  req_op = MD_OP_MUL;
   logic [1:0]  req_out_sel = MD_OUT_LO;
   logic        req_in_1_signed = 1'b0;
   logic        req_in_2_signed = 1'b0;
   logic [63:0] req_in_1 = '0;
   logic [63:0] req_in_2 = '0;
   logic        resp_valid;
   logic [63:0] resp_result;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [63:0] sb[$];
   int          lat[$];
   int          accepts[$];
   logic [63:0] last_res = '0;

   xvec2_vscale_vec_mul_div dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_kill(req_kill), .req_op(req_op), .req_out_sel(req_out_sel),
      .req_in_1_signed(req_in_1_signed), .req_in_2_signed(req_in_2_signed),
      .req_in_1(req_in_1), .req_in_2(req_in_2),
      .resp_valid(resp_valid), .resp_result(resp_result)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lane_model(logic [1:0] op, logic [1:0] sel, logic s1, logic s2,
                                              logic [31:0] a, logic [31:0] b);
      logic signed [65:0] xa, xb, p;
      xa = s1 ? {{34{a[31]}}, a} : {34'b0, a};
      xb = s2 ? {{34{b[31]}}, b} : {34'b0, b};
      p = xa * xb;
      if (op == MD_OP_MUL) return (sel == MD_OUT_HI) ? p[63:32] : p[31:0];
      if (b == 0) return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
      if (s1 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == MD_OP_DIV) ? a : 32'h0;
      if (s1) return (op == MD_OP_DIV) ? $signed(a) / $signed(b) : $signed(a) % $signed(b);
      return (op == MD_OP_DIV) ? a / b : a % b;
   endfunction

   function automatic logic [63:0] model(logic [1:0] op, logic [1:0] sel, logic s1, logic s2,
                                         logic [63:0] a, logic [63:0] b);
      logic [63:0] r;
      for (int i = 0; i < 2; i++) r[i*32 +: 32] = lane_model(op, sel, s1, s2, a[i*32 +: 32], b[i*32 +: 32]);
      return r;
   endfunction

   always @(posedge clk) begin
      if (!reset && req_valid && req_ready && !req_kill) begin
         sb.push_back(model(req_op, req_out_sel, req_in_1_signed, req_in_2_signed, req_in_1, req_in_2));
         lat.push_back(cyc);
         accepts.push_back(cyc);
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (resp_valid) begin
         if (sb.size() == 0) check("unexpected_resp", {63'b0, resp_valid}, 64'd0);
         else begin
            check("result", resp_result, sb.pop_front());
            check("latency", 64'(cyc - lat.pop_front()), 64'd34);
            last_res = resp_result;
         end
      end
   end

   task automatic drive(logic [1:0] op, logic [1:0] sel, logic s1, logic s2, logic [63:0] a, logic [63:0] b);
      req_op = op;
      req_out_sel = sel;
      req_in_1_signed = s1;
      req_in_2_signed = s2;
      req_in_1 = a;
      req_in_2 = b;
   endtask

   task automatic issue(logic [1:0] op, logic [1:0] sel, logic s1, logic s2, logic [63:0] a, logic [63:0] b);
      int n0, k;
      k = 0;
      while (!req_ready && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      n0 = accepts.size();
      drive(op, sel, s1, s2, a, b);
      req_valid = 1'b1;
      @(negedge clk); #1;
      req_valid = 1'b0;
      check("accept", 64'(accepts.size() - n0), 64'd1);
   endtask

   task automatic wait_resp(bit busy);
      int n;
      n = 0;
      while (sb.size() > 0 && n < 80) begin
         if (busy) check("ready_busy", {63'b0, req_ready}, 64'd0);
         @(negedge clk); #1;
         n++;
      end
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic run(logic [1:0] op, logic [1:0] sel, logic s1, logic s2, logic [63:0] a, logic [63:0] b);
      issue(op, sel, s1, s2, a, b);
      wait_resp(1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, k;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready", {63'b0, req_ready}, 64'd1);
      check("rst_valid", {63'b0, resp_valid}, 64'd0);
      check("rst_result", resp_result, 64'd0);
      reset = 1'b0;
      @(negedge clk); #1;

      issue(MD_OP_MUL, MD_OUT_LO, 0, 0, 64'hFFFF_FFFF_0000_0007, 64'h0000_0002_0000_0006);
      wait_resp(1'b1);
      check("mul_lo", last_res, 64'hFFFF_FFFE_0000_002A);
      @(negedge clk); #1;
      check("ready_idle", {63'b0, req_ready}, 64'd1);

      run(MD_OP_MUL, MD_OUT_HI, 1, 1, 64'h8000_0000_FFFF_FFFE, 64'h8000_0000_0000_0003);
      check("mul_hi_ss", last_res, 64'h4000_0000_FFFF_FFFF);
      run(MD_OP_DIV, MD_OUT_LO, 1, 1, 64'h0000_0064_FFFF_FFF9, 64'h0000_0000_0000_0002);
      check("div_s", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
      run(MD_OP_REM, MD_OUT_LO, 1, 1, 64'h0000_0064_FFFF_FFF9, 64'h0000_0000_0000_0002);
      check("rem_s", last_res, 64'h0000_0064_FFFF_FFFF);
      run(MD_OP_DIV, MD_OUT_LO, 1, 1, 64'h0000_0014_8000_0000, 64'hFFFF_FFFD_FFFF_FFFF);
      check("div_ovf", last_res, 64'hFFFF_FFFA_8000_0000);
      run(MD_OP_REM, MD_OUT_LO, 1, 1, 64'h0000_0014_8000_0000, 64'hFFFF_FFFD_FFFF_FFFF);
      check("rem_ovf", last_res, 64'h0000_0002_0000_0000);
      run(MD_OP_DIV, MD_OUT_LO, 1, 1, 64'hFFFF_FFFB_0000_0009, 64'h0000_0000_0000_0000);
      check("div0_neg", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
      run(MD_OP_MUL, MD_OUT_HI, 1, 0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_0000_0004);

      for (int i = 0; i < 8; i++) begin
         logic [1:0] op, sel;
         logic s;
         logic [63:0] a, b;
         op = 2'($urandom_range(0, 2));
         sel = 2'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         a = {$urandom, $urandom};
         b = (i == 3) ? {$urandom, 32'h0} : {$urandom, $urandom} >> $urandom_range(0, 40);
         run(op, sel, s, (op == MD_OP_MUL) ? 1'($urandom_range(0, 1)) : s, a, b);
      end

      issue(MD_OP_DIV, MD_OUT_LO, 0, 0, 64'h0000_1234_0000_5678, 64'h0000_0011_0000_0003);
      repeat (9) begin
         @(negedge clk); #1;
      end
      req_kill = 1'b1;
      @(negedge clk); #1;
      req_kill = 1'b0;
      check("kill_ready", {63'b0, req_ready}, 64'd1);
      if (sb.size() > 0) begin
         void'(sb.pop_back());
         void'(lat.pop_back());
      end
      repeat (40) @(negedge clk);
      #1;
      run(MD_OP_DIV, MD_OUT_LO, 0, 0, 64'h0000_1234_0000_5678, 64'h0000_0011_0000_0003);
      check("after_kill", last_res, 64'h0000_0112_0000_1CD2);

      base = accepts.size();
      drive(MD_OP_MUL, MD_OUT_LO, 0, 0, 64'h1, 64'h2);
      req_valid = 1'b1;
      req_kill = 1'b1;
      @(negedge clk); #1;
      req_valid = 1'b0;
      req_kill = 1'b0;
      check("kill_noaccept", 64'(accepts.size() - base), 64'd0);
      check("kill_idle", {63'b0, req_ready}, 64'd1);

      issue(MD_OP_MUL, MD_OUT_LO, 0, 0, 64'h3, 64'h5);
      repeat (5) begin
         @(negedge clk); #1;
      end
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      check("mid_rst_ready", {63'b0, req_ready}, 64'd1);
      check("mid_rst_valid", {63'b0, resp_valid}, 64'd0);
      check("mid_rst_result", resp_result, 64'd0);
      if (sb.size() > 0) begin
         void'(sb.pop_back());
         void'(lat.pop_back());
      end
      repeat (40) @(negedge clk);
      #1;

      base = accepts.size();
      drive(MD_OP_DIV, MD_OUT_LO, 0, 0, 64'hDEAD_BEEF_0BAD_F00D, 64'h0000_0100_0000_0007);
      req_valid = 1'b1;
      k = 0;
      while (accepts.size() < base + 3 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      req_valid = 1'b0;
      check("b2b_count", 64'(accepts.size() - base), 64'd3);
      if (accepts.size() >= base + 3) begin
         check("b2b_gap1", 64'(accepts[base+1] - accepts[base]), 64'd35);
         check("b2b_gap2", 64'(accepts[base+2] - accepts[base+1]), 64'd35);
      end
      wait_resp(1'b0);
      repeat (3) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/xvec2_vscale_vec_mul_div.md
Name: xvec2_vscale_vec_mul_div

Overview:
- Iterative multiply/divide/remainder unit for the xvec2 datapath.
- Sits directly downstream of the vector source-B operand mux: it consumes the muxed operand as its second input alongside source A.
- Operates on LANES independent LANE_W-bit lanes packed into one `VEC_XPR_LEN-bit word, with a shared FSM and a valid/ready request, valid-only response.
- Fixed multi-cycle latency; the pipeline stalls on req_ready/resp_valid.

Parameters:
- LANES, 2, number of packed lanes; LANES*LANE_W must equal `VEC_XPR_LEN.
- LANE_W, 32, lane width in bits (= `XPR_LEN).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_kill  input  1  abort any in-flight operation (pipeline flush).
- req_op  input  `MD_OP_WIDTH  MD_OP_MUL / MD_OP_DIV / MD_OP_REM.
- req_out_sel  input  `MD_OUT_SEL_WIDTH  MD_OUT_LO / MD_OUT_HI; used for MUL only.
- req_in_1_signed  input  1  treat src A lanes as signed.
- req_in_2_signed  input  1  treat src B lanes as signed.
- req_in_1  input  `VEC_XPR_LEN  src A, lane i = bits [i*LANE_W +: LANE_W].
- req_in_2  input  `VEC_XPR_LEN  src B (from src-B mux), same packing.
- resp_valid  output  1  one-cycle result strobe.
- resp_result  output  `VEC_XPR_LEN  packed per-lane result.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE, counter=0.
  - resp_valid=0, resp_result=0, req_ready=1.
  - All lane accumulators cleared.
- FSM states: IDLE, COMPUTE, SETUP_OUTPUT, DONE.
  - IDLE -> COMPUTE on req_valid & req_ready & ~req_kill.
    - Latch op, out_sel and signedness.
    - Per lane: take operand magnitudes (negate if signed and negative); record result-negate flags.
    - counter = LANE_W-1.
  - COMPUTE: one shift-add (MUL) or restoring shift-subtract (DIV/REM) step per cycle, all lanes in lockstep. Decrement counter; go to SETUP_OUTPUT when counter==0 (exactly LANE_W COMPUTE cycles).
  - SETUP_OUTPUT: apply sign correction per lane; select lo/hi product, quotient or remainder; register into resp_result; go to DONE.
  - DONE: resp_valid=1 for exactly one cycle; go to IDLE. No backpressure: the consumer must sample on resp_valid.
- Latency: accept in cycle 0 -> resp_valid in cycle LANE_W+2 (34 at defaults). Next accept is possible in cycle LANE_W+3.
- resp_result holds its value after DONE until the next SETUP_OUTPUT overwrites it.
- req_kill in any non-IDLE state -> IDLE next cycle, no resp_valid. req_kill in DONE suppresses nothing already driven that cycle.
- req_kill concurrent with req_valid in IDLE: the request is not accepted.
- Sign rules:
  - Quotient negative iff the operand signs differ (signed op).
  - Remainder takes the sign of the dividend.
  - MUL HI with mixed signedness implements MULHSU.
- Boundary cases, per lane, independent of the other lanes:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (-2^(LANE_W-1) / -1): quotient = -2^(LANE_W-1), remainder = 0.
  - MUL LO is the low LANE_W bits; MUL HI is the upper LANE_W bits of the 2*LANE_W product.
- No carries or borrows ever cross a lane boundary.
- Reset mid-operation: immediate return to reset state; no response.

Decomposition:
- The following belong in the shared vscale_md_constants.vh:
  - MD_OP_* and MD_OUT_* codes.
  - `MD_OP_WIDTH and `MD_OUT_SEL_WIDTH.
  - FSM state encodings (MD_STATE_*, 2 bits).
- `VEC_XPR_LEN comes from rv32_opcodes.vh.
- Sub-module xvec2_vscale_md_lane, instantiated LANES times:
  - Per-lane operand/accumulator registers, one iteration step, and sign fix-up.
  - Driven by the shared FSM's load/step/finish strobes.

Test Plan:
- MUL LO unsigned, lane0 = 7*6, lane1 = 0xFFFFFFFF*2 -> resp_valid at cycle 34; lanes = 42 and 0xFFFFFFFE. req_ready low from cycle 1 to 34.
- MUL HI signed*signed, lane0 = -2*3, lane1 = 0x80000000*0x80000000 -> lanes = 0xFFFFFFFF and 0x40000000.
- DIV signed, lane0 = -7/2, lane1 = 100/0 -> lanes = 0xFFFFFFFD and 0xFFFFFFFF. REM with the same operands -> 0xFFFFFFFF and 100.
- DIV signed overflow, lane0 = 0x80000000/-1 -> quotient 0x80000000; REM -> 0.
- Kill: assert req_kill at cycle 10 of a DIV -> no resp_valid for 40 cycles; req_ready=1 at cycle 11; a following request completes normally.
- Reset asserted mid-COMPUTE -> next cycle req_ready=1, resp_valid=0, resp_result=0. Back-to-back requests with req_valid held high are accepted every 35 cycles.
